// File: rtl/alu_mc_if.sv
// Operand/result bundle between decode/register-read and the alu_mc execute unit.
// Signal names are kept identical to the original port list.
interface alu_mc_if #(
    parameter int WIDTH = 16,
    parameter int IMM_W = 8
);
    logic             I_valid;
    logic             O_ready;
    logic [4:0]       I_aluop;
    logic [WIDTH-1:0] I_dataA;
    logic [WIDTH-1:0] I_dataB;
    logic [IMM_W-1:0] I_imm;
    logic             O_valid;
    logic [WIDTH-1:0] O_dataResult;
    logic [3:0]       O_flags;
    logic             O_shlBranch;
    logic             O_illegal;

    modport master (
        output I_valid, I_aluop, I_dataA, I_dataB, I_imm,
        input  O_ready, O_valid, O_dataResult, O_flags, O_shlBranch, O_illegal
    );

    modport slave (
        input  I_valid, I_aluop, I_dataA, I_dataB, I_imm,
        output O_ready, O_valid, O_dataResult, O_flags, O_shlBranch, O_illegal
    );
endinterface

// File: rtl/alu_mc.sv
// Parametrised ALU with status flags; single-cycle ops complete in IDLE,
// MUL runs a WIDTH-step shift-add sequence while O_ready is held low.
module alu_mc #(
    parameter int WIDTH = 16,
    parameter int IMM_W = 8
) (
    input  logic     I_clk,
    input  logic     I_rst,
    alu_mc_if.slave  bus
);
    localparam int SW = $clog2(WIDTH);

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t             r_state, w_next;
    logic               w_ready, w_accept, w_last, w_m;
    logic [3:0]         w_op;
    logic [WIDTH-1:0]   w_a, w_b, w_res, w_immz, w_maga, w_magb;
    logic [WIDTH:0]     w_sum, w_diff;
    logic [SW-1:0]      w_shamt;
    logic               w_c, w_v, w_branch, w_illegal;
    logic [3:0]         w_flags;

    logic [2*WIDTH-1:0] r_acc, r_mcand, w_prod, w_fin;
    logic [WIDTH-1:0]   r_mplier, w_mres, w_mhi;
    logic [SW-1:0]      r_cnt;
    logic               r_neg, r_signed, w_mc;

    logic               r_valid, r_branch, r_illegal;
    logic [WIDTH-1:0]   r_result;
    logic [3:0]         r_flags;

    assign w_op     = bus.I_aluop[4:1];
    assign w_m      = bus.I_aluop[0];
    assign w_a      = bus.I_dataA;
    assign w_b      = bus.I_dataB;
    assign w_accept = bus.I_valid && w_ready;
    assign w_last   = (r_cnt == SW'(WIDTH - 1));

    always_ff @(posedge I_clk) begin
        if (I_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_ready = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                if (bus.I_valid && w_op == 4'd6) w_next = S_MUL;
            end
            S_MUL: if (w_last) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Single-cycle datapath
    always_comb begin
        w_sum     = {1'b0, w_a} + {1'b0, w_b};
        w_diff    = {1'b0, w_a} - {1'b0, w_b};
        w_shamt   = w_b[SW-1:0];
        w_immz    = WIDTH'(bus.I_imm);
        w_res     = '0;
        w_c       = 1'b0;
        w_v       = 1'b0;
        w_branch  = 1'b0;
        w_illegal = 1'b0;
        case (w_op)
            4'd0: begin
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = (w_a[WIDTH-1] == w_b[WIDTH-1]) && (w_res[WIDTH-1] != w_a[WIDTH-1]);
            end
            4'd1: begin
                w_res = w_diff[WIDTH-1:0];
                w_c   = w_diff[WIDTH];
                w_v   = (w_a[WIDTH-1] != w_b[WIDTH-1]) && (w_res[WIDTH-1] != w_a[WIDTH-1]);
            end
            4'd2:  w_res = w_a | w_b;
            4'd3:  w_res = w_a & w_b;
            4'd4:  w_res = w_a ^ w_b;
            4'd5:  w_res = ~w_a;
            4'd6:  w_res = '0;
            4'd8:  w_res = w_m ? (w_immz << (WIDTH - IMM_W)) : w_immz;
            4'd9:  w_res = {{(WIDTH-5){1'b0}}, (w_b == '0), (w_a == '0),
                            w_m ? ($signed(w_a) < $signed(w_b)) : (w_a < w_b),
                            w_m ? ($signed(w_a) > $signed(w_b)) : (w_a > w_b),
                            (w_a == w_b)};
            4'd10: w_res = w_a << w_shamt;
            4'd11: w_res = w_m ? $unsigned($signed(w_a) >>> w_shamt) : (w_a >> w_shamt);
            4'd12: begin
                w_res    = w_m ? w_a : w_immz;
                w_branch = 1'b1;
            end
            4'd13: begin
                w_res    = w_a;
                w_branch = w_b[{w_m, bus.I_imm[1:0]}];
            end
            default: w_illegal = 1'b1;
        endcase
        w_flags = w_illegal ? 4'b0000 : {w_res[WIDTH-1], w_v, w_c, (w_res == '0)};
    end

    // Signed MUL multiplies magnitudes; the final step folds in the sign correction
    always_comb begin
        w_maga = (w_m && w_a[WIDTH-1]) ? (~w_a + 1'b1) : w_a;
        w_magb = (w_m && w_b[WIDTH-1]) ? (~w_b + 1'b1) : w_b;
        w_prod = r_acc + (r_mplier[0] ? r_mcand : '0);
        w_fin  = r_neg ? (~w_prod + 1'b1) : w_prod;
        w_mres = w_fin[WIDTH-1:0];
        w_mhi  = w_fin[2*WIDTH-1:WIDTH];
        w_mc   = r_signed ? (w_mhi != {WIDTH{w_mres[WIDTH-1]}}) : (w_mhi != '0);
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            r_valid   <= 1'b0;
            r_result  <= '0;
            r_flags   <= '0;
            r_branch  <= 1'b0;
            r_illegal <= 1'b0;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_cnt     <= '0;
            r_neg     <= 1'b0;
            r_signed  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: if (w_accept) begin
                    if (w_op == 4'd6) begin
                        r_acc    <= '0;
                        r_mcand  <= {{WIDTH{1'b0}}, w_maga};
                        r_mplier <= w_magb;
                        r_cnt    <= '0;
                        r_neg    <= w_m && (w_a[WIDTH-1] ^ w_b[WIDTH-1]);
                        r_signed <= w_m;
                    end else begin
                        r_valid   <= 1'b1;
                        r_result  <= w_res;
                        r_flags   <= w_flags;
                        r_branch  <= w_branch;
                        r_illegal <= w_illegal;
                    end
                end
                S_MUL: begin
                    r_acc    <= w_prod;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_valid   <= 1'b1;
                        r_result  <= w_mres;
                        r_flags   <= {w_mres[WIDTH-1], 1'b0, w_mc, (w_mres == '0)};
                        r_branch  <= 1'b0;
                        r_illegal <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.O_ready      = w_ready;
    assign bus.O_valid      = r_valid;
    assign bus.O_dataResult = r_result;
    assign bus.O_flags      = r_flags;
    assign bus.O_shlBranch  = r_branch;
    assign bus.O_illegal    = r_illegal;
endmodule
